// File: rtl/commit_trace_checker.sv
// Compares live processor commit events against an expected architectural trace stream.
// Latency: a commit record captured at edge N is compared no earlier than edge N+1, one sub-event per cycle.
// Backpressure: exp_ready follows exp_valid only while comparing; commits arriving with a full queue are dropped and flagged.
module commit_trace_checker #(
  parameter int RQ_DEPTH = 8,
  parameter int MAX_ERR  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write,
  input  logic [2:0]  wr_reg,
  input  logic [15:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        halt,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic [15:0] exp_a,
  input  logic [15:0] exp_d,
  output logic        done,
  output logic        pass,
  output logic [7:0]  mismatch_count,
  output logic [15:0] first_fail_idx,
  output logic        overflow
);

  localparam int AW = $clog2(RQ_DEPTH);

  // Entry kinds; the value doubles as the sub-event slot within a record.
  localparam logic [1:0] K_REG   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_HALT  = 2'd3;

  localparam logic [7:0] ERR_SAT = 8'(MAX_ERR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Record storage: flags are {h, s, l, r} so bit k matches sub-event slot k.
  logic [3:0]  r_q_flg  [RQ_DEPTH];
  logic [2:0]  r_q_reg  [RQ_DEPTH];
  logic [15:0] r_q_wd   [RQ_DEPTH];
  logic [15:0] r_q_addr [RQ_DEPTH];
  logic [15:0] r_q_md   [RQ_DEPTH];

  // Pointers carry one extra bit so full and empty can be told apart.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sub;
  logic [15:0] r_idx;
  logic [7:0]  r_err;
  logic [15:0] r_ffail;
  logic        r_ovf;

  logic        w_empty;
  logic        w_full;
  logic        w_cap;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  logic        w_ready;
  logic        w_consume;
  logic        w_match;
  logic [3:0]  w_cap_flg;
  logic [15:0] w_cap_md;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  logic [3:0]  w_h_flg;
  logic [2:0]  w_h_reg;
  logic [15:0] w_h_wd;
  logic [15:0] w_h_addr;
  logic [15:0] w_h_md;

  logic [1:0]  w_first_sub;
  logic [1:0]  w_nxt_sub;
  logic        w_nxt_found;

  assign w_wr_idx = r_wptr[AW-1:0];
  assign w_rd_idx = r_rptr[AW-1:0];
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A simultaneous read and write is recorded as a store only; memory data follows the surviving access.
  assign w_cap     = (reg_write | mem_read | mem_write | halt) & (r_state != S_DONE);
  assign w_cap_flg = {halt, mem_write, mem_read & ~mem_write, reg_write};
  assign w_cap_md  = (mem_read & ~mem_write) ? mem_data_out : mem_data_in;

  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

  assign w_h_flg  = r_q_flg[w_rd_idx];
  assign w_h_reg  = r_q_reg[w_rd_idx];
  assign w_h_wd   = r_q_wd[w_rd_idx];
  assign w_h_addr = r_q_addr[w_rd_idx];
  assign w_h_md   = r_q_md[w_rd_idx];

  // Locate the first set flag of the head record and the next set flag after the current slot.
  always_comb begin
    w_first_sub = 2'd0;
    w_nxt_sub   = 2'd0;
    w_nxt_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (w_h_flg[k]) begin
        w_first_sub = 2'(k);
      end
      if (w_h_flg[k] && (k > int'(r_sub))) begin
        w_nxt_found = 1'b1;
        w_nxt_sub   = 2'(k);
      end
    end
  end

  // Compare the offered expected entry against the current sub-event of the head record.
  always_comb begin
    w_match = 1'b0;
    case (r_sub)
      K_REG:   w_match = (exp_kind == K_REG) && (exp_a[2:0] == w_h_reg) && (exp_d == w_h_wd);
      K_LOAD:  w_match = (exp_kind == K_LOAD) && (exp_a == w_h_addr) && (exp_d == w_h_md);
      K_STORE: w_match = (exp_kind == K_STORE) && (exp_a == w_h_addr) && (exp_d == w_h_md);
      default: w_match = (exp_kind == K_HALT);
    endcase
  end

  // Next-state and handshake decode for the compare sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_consume   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_CMP;
        end else if (r_ovf) begin
          // Records were lost and nothing is left to check: finish early as a failure.
          w_state_nxt = S_DONE;
        end
      end
      S_CMP: begin
        w_ready = exp_valid;
        if (exp_valid) begin
          w_consume = 1'b1;
          if (!w_nxt_found) begin
            w_pop       = 1'b1;
            w_state_nxt = w_h_flg[3] ? S_DONE : S_IDLE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Queue pointers, sub-event pointer, entry index and error bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_sub   <= 2'd0;
      r_idx   <= 16'd0;
      r_err   <= 8'd0;
      r_ffail <= 16'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_sub <= w_first_sub;
      end else if (w_consume && w_nxt_found) begin
        r_sub <= w_nxt_sub;
      end
      if (w_consume) begin
        r_idx <= r_idx + 16'd1;
        if (!w_match) begin
          if (r_err == 8'd0) begin
            r_ffail <= r_idx;
          end
          if (r_err != ERR_SAT) begin
            r_err <= r_err + 8'd1;
          end
        end
      end
    end
  end

  // Record payload storage; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_flg[w_wr_idx]  <= w_cap_flg;
      r_q_reg[w_wr_idx]  <= wr_reg;
      r_q_wd[w_wr_idx]   <= wr_data;
      r_q_addr[w_wr_idx] <= mem_addr;
      r_q_md[w_wr_idx]   <= w_cap_md;
    end
  end

  assign exp_ready      = w_ready;
  assign done           = (r_state == S_DONE);
  assign pass           = (r_state == S_DONE) && (r_err == 8'd0) && !r_ovf;
  assign mismatch_count = r_err;
  assign first_fail_idx = r_ffail;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Self-checking bench for commit_trace_checker: directed trace scenarios plus randomized traces.
// A reference model pairs the flattened commit sub-events with expected entries positionally.
// A monitor pops per-entry expected results on every handshake and checks the counters.
module tb_commit_trace_checker;

  localparam int RQ_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write, mem_read, mem_write, halt, exp_valid;
  logic [2:0]  wr_reg;
  logic [15:0] wr_data, mem_addr, mem_data_in, mem_data_out, exp_a, exp_d;
  logic [1:0]  exp_kind;
  logic        exp_ready, done, pass, overflow;
  logic [7:0]  mismatch_count;
  logic [15:0] first_fail_idx;

  commit_trace_checker #(.RQ_DEPTH(RQ_DEPTH), .MAX_ERR(255)) dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_a(exp_a), .exp_d(exp_d),
    .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rw; logic [2:0] rg; logic [15:0] wd;
    logic mr; logic mw; logic [15:0] addr; logic [15:0] din; logic [15:0] dout;
    logic h; int gap;
  } cm_t;
  typedef struct { logic [1:0] kind; logic [15:0] a; logic [15:0] d; } ent_t;
  typedef struct { logic [7:0] cnt; logic [15:0] ff; } res_t;

  cm_t  cms[$];
  ent_t subs[$];
  ent_t ents[$];
  res_t sb[$];
  int   cum[$];
  int   hs_cyc[$];
  logic ovf_obs[$];

  int n_cmp = 0;
  int n_bad = 0;
  int hs_count = 0;
  int cyc = 0;
  logic [7:0]  x_cnt;
  logic [15:0] x_ff;
  logic        x_pass, x_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic cm_t mk(input logic rw, input logic [2:0] rg, input logic [15:0] wd,
                             input logic mr, input logic mw, input logic [15:0] addr,
                             input logic [15:0] din, input logic [15:0] dout,
                             input logic h, input int gap);
    cm_t c;
    c.rw = rw; c.rg = rg; c.wd = wd; c.mr = mr; c.mw = mw;
    c.addr = addr; c.din = din; c.dout = dout; c.h = h; c.gap = gap;
    return c;
  endfunction

  // Flatten commit records into the architectural sub-event order REG, LOAD, STORE, HALT.
  task automatic build_subs();
    subs.delete();
    cum.delete();
    foreach (cms[k]) begin
      if (cms[k].rw) subs.push_back('{2'd0, {13'd0, cms[k].rg}, cms[k].wd});
      if (cms[k].mr && !cms[k].mw) subs.push_back('{2'd1, cms[k].addr, cms[k].dout});
      if (cms[k].mw) subs.push_back('{2'd2, cms[k].addr, cms[k].din});
      if (cms[k].h) subs.push_back('{2'd3, 16'd0, 16'd0});
      cum.push_back(subs.size());
    end
  endtask

  // Pair expected entries with sub-events one-to-one and derive running results and final verdict.
  task automatic build_model(input logic ovf_exp);
    int   cnt = 0;
    int   ff = 0;
    logic mm;
    sb.delete();
    for (int i = 0; i < ents.size() && i < subs.size(); i++) begin
      if (ents[i].kind != subs[i].kind) mm = 1'b1;
      else if (subs[i].kind == 2'd0) mm = (ents[i].a[2:0] != subs[i].a[2:0]) || (ents[i].d != subs[i].d);
      else if (subs[i].kind == 2'd3) mm = 1'b0;
      else mm = (ents[i].a != subs[i].a) || (ents[i].d != subs[i].d);
      if (mm) begin
        if (cnt == 0) ff = i;
        if (cnt < 255) cnt++;
      end
      sb.push_back('{8'(cnt), 16'(ff)});
    end
    x_cnt  = 8'(cnt);
    x_ff   = 16'(ff);
    x_ovf  = ovf_exp;
    x_pass = (cnt == 0) && !ovf_exp;
  endtask

  task automatic idle();
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
    wr_reg = 3'($urandom); wr_data = 16'($urandom); mem_addr = 16'($urandom);
    mem_data_in = 16'($urandom); mem_data_out = 16'($urandom);
  endtask

  function automatic int recs_done();
    int c = 0;
    foreach (cum[j]) if (cum[j] <= hs_count) c++;
    return c;
  endfunction

  task automatic drive_commits(input bit throttle);
    int budget;
    foreach (cms[k]) begin
      budget = 2000;
      repeat (cms[k].gap) begin @(negedge clk); idle(); end
      while (throttle && (k - recs_done()) >= RQ_DEPTH - 2 && budget > 0) begin
        @(negedge clk); idle(); budget--;
      end
      @(negedge clk);
      reg_write = cms[k].rw; wr_reg = cms[k].rg; wr_data = cms[k].wd;
      mem_read = cms[k].mr; mem_write = cms[k].mw; mem_addr = cms[k].addr;
      mem_data_in = cms[k].din; mem_data_out = cms[k].dout; halt = cms[k].h;
      @(posedge clk);
      #1 ovf_obs.push_back(overflow);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic drive_exp(input int stall, input int vprob);
    int i = 0;
    int budget = 4000;
    repeat (stall) begin
      @(negedge clk);
      exp_valid = 1'b0;
      #1;
      chk("stall_ready", exp_ready, 0);
      chk("stall_count", mismatch_count, 0);
    end
    while (i < ents.size() && budget > 0) begin
      @(negedge clk);
      budget--;
      if ($urandom_range(99) < vprob) begin
        exp_valid = 1'b1; exp_kind = ents[i].kind; exp_a = ents[i].a; exp_d = ents[i].d;
        #1;
        if (exp_ready) begin i++; hs_count = i; end
      end else begin
        exp_valid = 1'b0; exp_kind = 2'($urandom); exp_a = 16'($urandom); exp_d = 16'($urandom);
      end
    end
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    exp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_scenario(input string nm, input int stall, input int vprob,
                              input bit throttle, input logic ovf_exp);
    int b = 0;
    hs_cyc.delete();
    ovf_obs.delete();
    hs_count = 0;
    build_model(ovf_exp);
    fork
      drive_commits(throttle);
      drive_exp(stall, vprob);
    join
    while (!done && b < 200) begin @(negedge clk); b++; end
    repeat (2) @(negedge clk);
    #3;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_pass"}, pass, x_pass);
    chk({nm, "_count"}, mismatch_count, x_cnt);
    chk({nm, "_ffail"}, first_fail_idx, x_ff);
    chk({nm, "_ovf"}, overflow, x_ovf);
    chk({nm, "_sb_left"}, sb.size(), 0);
  endtask

  // Monitor: on every consumed entry, check the counters one edge later against the scoreboard.
  initial begin
    bit   pend;
    res_t pr;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("hs_count", mismatch_count, pr.cnt);
          chk("hs_ffail", first_fail_idx, pr.ff);
          pend = 1'b0;
        end
        if (exp_valid && exp_ready) begin
          hs_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hs_unexpected: consumed entry with nothing expected (t=%0t)", $time);
          end else begin
            pr = sb.pop_front();
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    exp_valid = 1'b0; exp_kind = 2'd0; exp_a = 16'd0; exp_d = 16'd0;
    #2;
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_count", mismatch_count, 0);
    chk("rst_ffail", first_fail_idx, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", exp_ready, 0);

    // Single REG then HALT.
    do_reset();
    cms.delete();
    cms.push_back(mk(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 1));
    cms.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    build_subs(); ents = subs;
    run_scenario("single_reg", 0, 100, 1, 0);

    // REG and LOAD in the same commit cycle.
    do_reset();
    cms.delete();
    cms.push_back(mk(1, 3'd2, 16'hBEEF, 1, 0, 16'h0040, 16'h0, 16'hBEEF, 0, 1));
    cms.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    build_subs(); ents = subs;
    run_scenario("reg_load", 0, 100, 1, 0);
    chk("reg_load_consec", (hs_cyc.size() >= 2) ? (hs_cyc[1] - hs_cyc[0]) : -1, 1);

    // STORE data mismatch at entry index 5.
    do_reset();
    cms.delete();
    for (int k = 0; k < 5; k++) cms.push_back(mk(1, 3'(k), 16'(16'h100 + k), 0, 0, 0, 0, 0, 0, 0));
    cms.push_back(mk(0, 0, 0, 0, 1, 16'h0010, 16'h00FF, 16'h0, 0, 0));
    cms.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    build_subs(); ents = subs;
    ents[5].d = 16'h00FE;
    run_scenario("store_mm", 0, 100, 1, 0);

    // Read and write in the same cycle are a STORE only, followed by an expected-stream stall.
    do_reset();
    cms.delete();
    cms.push_back(mk(0, 0, 0, 1, 1, 16'h0200, 16'hCAFE, 16'h1111, 0, 0));
    for (int k = 0; k < 3; k++) cms.push_back(mk(1, 3'(k + 4), 16'(16'hA000 + k), 0, 0, 0, 0, 0, 0, 0));
    cms.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    build_subs(); ents = subs;
    run_scenario("stall", 14, 100, 0, 0);

    // Nine back-to-back commits with no expected stream: the ninth is dropped.
    do_reset();
    cms.delete();
    for (int k = 0; k < 9; k++) cms.push_back(mk(1, 3'(k), 16'(16'h5000 + k), 0, 0, 0, 0, 0, 0, 0));
    build_subs(); ents = subs;
    void'(ents.pop_back());
    run_scenario("overflow", 12, 100, 0, 1);
    chk("ovf_after_8", (ovf_obs.size() >= 9) ? ovf_obs[7] : 1'bx, 0);
    chk("ovf_after_9", (ovf_obs.size() >= 9) ? ovf_obs[8] : 1'bx, 1);

    // Asynchronous reset while comparing, then a clean run.
    do_reset();
    cms.delete();
    for (int k = 0; k < 10; k++) cms.push_back(mk(1, 3'(k), 16'(k), 0, 0, 0, 0, 0, 0, 0));
    build_subs();
    drive_commits(0);
    @(negedge clk);
    exp_valid = 1'b1; exp_kind = 2'd0; exp_a = 16'd0; exp_d = 16'd0;
    #1;
    chk("arst_pre_ready", exp_ready, 1);
    chk("arst_pre_ovf", overflow, 1);
    rst = 1'b0;
    #1;
    chk("arst_ready", exp_ready, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_done", done, 0);
    chk("arst_count", mismatch_count, 0);
    chk("arst_ffail", first_fail_idx, 0);
    exp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cms.delete();
    cms.push_back(mk(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 1));
    cms.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    build_subs(); ents = subs;
    run_scenario("after_arst", 0, 100, 1, 0);

    // Randomized traces with occasional corrupted expected entries.
    for (int it = 0; it < 6; it++) begin
      int n;
      do_reset();
      cms.delete();
      n = $urandom_range(4, 14);
      for (int k = 0; k < n; k++) begin
        cm_t c;
        c = mk($urandom, 3'($urandom), 16'($urandom), $urandom, $urandom, 16'($urandom),
               16'($urandom), 16'($urandom), (k == n - 1), $urandom_range(0, 3));
        if (!c.rw && !c.mr && !c.mw && !c.h) c.rw = 1'b1;
        cms.push_back(c);
      end
      build_subs();
      ents.delete();
      foreach (subs[i]) begin
        ent_t e;
        e = subs[i];
        if (e.kind == 2'd0) e.a = {13'($urandom), e.a[2:0]};
        if ($urandom_range(99) < 15) begin
          case ($urandom_range(2))
            0: e.d = e.d ^ (16'h1 << $urandom_range(15));
            1: e.a = e.a ^ (16'h1 << $urandom_range(15));
            default: e.kind = 2'($urandom);
          endcase
        end
        ents.push_back(e);
      end
      run_scenario("random", 0, $urandom_range(40, 100), 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_checker.md
Name: commit_trace_checker

Overview:
- Synthesizable checker that reads an expected architectural trace and compares it against live commit events from the processor.
- Consumes an ordered stream of expected REG/LOAD/STORE/HALT entries and matches them against the processor's writeback/memory commit signals.
- Reports pass/fail, a mismatch count and the first failing entry index.
- Sits beside proc_hier and is fed from a trace ROM or host stream on the expected side.

Parameters:
- RQ_DEPTH, 8, commit-record queue depth in entries (power of 2, >=2).
- MAX_ERR, 255, saturation value of mismatch_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- reg_write  in  1  register file write this cycle.
- wr_reg  in  3  destination register.
- wr_data  in  16  register write data.
- mem_read  in  1  valid memory read this cycle.
- mem_write  in  1  valid memory write this cycle.
- mem_addr  in  16  memory address.
- mem_data_in  in  16  store data.
- mem_data_out  in  16  load data.
- halt  in  1  halt reached memory stage.
- exp_valid  in  1  expected entry available.
- exp_ready  out  1  expected entry consumed this cycle.
- exp_kind  in  2  entry kind: 0 REG, 1 LOAD, 2 STORE, 3 HALT.
- exp_a  in  16  register number (REG, low 3 bits significant) or address (LOAD/STORE); ignored for HALT.
- exp_d  in  16  expected data; ignored for HALT.
- done  out  1  checking finished (HALT compared, or fatal error).
- pass  out  1  valid when done: 1 = no mismatch and no overflow.
- mismatch_count  out  8  number of mismatching sub-events, saturating at MAX_ERR.
- first_fail_idx  out  16  index of the first mismatching expected entry (0-based).
- overflow  out  1  sticky: commit record dropped because the queue was full.

Behaviour:
- Reset (rst=0, async): queue empty; FSM in IDLE; all outputs 0; entry index 0.
- Capture: on each posedge where reg_write | mem_read | mem_write | halt, and done=0, push one record.
  - Record fields: flags {r, l, s, h}, wr_reg, wr_data, mem_addr, and mem data (load data if l, else store data).
  - Queue full at capture: record is discarded, overflow<=1.
  - mem_read and mem_write both set: treated as a STORE only (l forced 0).
- Sub-event order within a record is fixed: REG, LOAD, STORE, HALT. Each set flag consumes exactly one expected entry.
- FSM states:
  - IDLE: queue non-empty -> CMP with sub-pointer at the first set flag of the head record.
  - CMP: exp_ready = exp_valid (combinational, only in CMP). On exp_valid:
    - Compare kind, address/register and data; HALT compares kind only; REG compares exp_a[2:0] to wr_reg.
    - Advance entry index and sub-pointer.
    - On mismatch: increment mismatch_count (saturating); capture first_fail_idx if this is the first mismatch.
    - After the last set flag: pop record, then -> IDLE, or -> DONE if the h flag was set.
    - No exp_valid: hold state, no compare, no pop.
  - DONE: done=1; pass = (mismatch_count==0 && !overflow). Terminal until reset. Further commits are ignored.
- Fatal early end: overflow set while queue is empty and FSM is in IDLE -> DONE with pass=0.
- Simultaneous push and pop on a full queue: the pop frees a slot and the push is accepted; no overflow.
- Queue pointers wrap modulo RQ_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Expected entry of a kind with no remaining sub-event: counted as a mismatch; the entry and the current sub-event are both consumed.
- Latency: a record captured at edge N is compared no earlier than edge N+1 (one per-cycle sub-event at best).
- Reset asserted mid-compare: all state cleared immediately, no partial update.

Test Plan:
- Single REG: commit reg_write wr_reg=3 wr_data=0x1234; expected {REG,3,0x1234}; then HALT on both sides -> done=1, pass=1, mismatch_count=0.
- Combined REG+LOAD: same-cycle reg_write r2=0xBEEF and mem_read addr 0x0040 data 0xBEEF; expected REG then LOAD -> 2 entries consumed on consecutive cycles, pass=1.
- Data mismatch: STORE addr 0x0010 data 0x00FF against expected data 0x00FE at entry index 5 -> mismatch_count=1, first_fail_idx=5, pass=0 after HALT.
- Expected stream stall: exp_valid held low 10 cycles with 4 records queued -> exp_ready=0, no state change; resumes matching in order once valid.
- Overflow: RQ_DEPTH=8, exp_valid=0, 9 consecutive commit cycles -> overflow=1 on the 9th; after drain and HALT, pass=0.
- Async reset: assert rst low mid-CMP -> all outputs 0 without waiting for a clock edge; a clean run after release passes.
